periph_uart: RTL

PERIPH_UART -- requirements
Module: periph_uart

---
 rtl/periph_uart.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/periph_uart.sv
// Memory-mapped 8N1 UART: 4-deep TX FIFO, single RX holding register, W1C error
// flags and a programmable bit divisor (bit period = DIVISOR+1 clk cycles).
module periph_uart #(
  parameter int          DataWidth      = 32,
  parameter logic [15:0] DefaultDivisor = 16'd433
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DataWidth-1:0]   data_periph_in,
  input  logic [3:0]             data_periph_write,
  output logic [4*DataWidth-1:0] data_periph_out,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  output logic                   irq
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [15:0]     divisor;
  logic [3:0][7:0] fifo_mem;
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      fifo_cnt;
  logic            fifo_empty, fifo_full, tx_push, tx_pop, tx_ovf_set, tx_busy;

  state_e      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;

  state_e      rx_state;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_prev, rx_done_ok, rx_done_err, rx_clr;
  logic [15:0] rx_cnt, rx_start_load;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift, rx_byte;
  logic        rx_valid, rx_overrun, tx_overflow, frame_error;
  logic [2:0]  w1c;
  logic [31:0] status;
  logic        unused_in;

  assign unused_in  = ^data_periph_in[DataWidth-1:16];
  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_full  = (fifo_cnt == 3'd4);
  // A full FIFO drops the write even if the head is popped on the same edge.
  assign tx_push    = data_periph_write[0] && !fifo_full;
  assign tx_ovf_set = data_periph_write[0] && fifo_full;
  assign tx_pop     = !fifo_empty && (tx_state == IDLE || (tx_state == STOP && tx_cnt == 16'd0));
  assign tx_busy    = (tx_state != IDLE);

  assign rx_s        = rx_sync[1];
  assign rx_done_ok  = (rx_state == STOP) && (rx_cnt == 16'd0) && rx_s;
  assign rx_done_err = (rx_state == STOP) && (rx_cnt == 16'd0) && !rx_s;
  assign rx_clr      = data_periph_write[1];
  assign w1c         = data_periph_write[2] ? data_periph_in[6:4] : 3'b000;
  // START waits floor((D+1)/2) cycles: D>>1 for odd D, (D>>1)-1 for even D (clamped at D=0).
  assign rx_start_load = (divisor[0] || divisor == 16'd0) ? {1'b0, divisor[15:1]}
                                                          : {1'b0, divisor[15:1]} - 16'd1;

  assign status = {25'b0, frame_error, tx_overflow, rx_overrun, rx_valid, tx_busy, fifo_full, fifo_empty};
  assign data_periph_out = {16'b0, divisor, status, 23'b0, rx_valid, rx_byte, 32'b0};
  assign irq = rx_valid | rx_overrun | tx_overflow | frame_error;

  always_ff @(posedge clk) begin
    if (tx_push) fifo_mem[wr_ptr] <= data_periph_in[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 2'd1;
      if (tx_pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b0, tx_push} - {2'b0, tx_pop};
    end
  end

  // Each bit reloads tx_cnt from DIVISOR, so divisor writes only apply at bit boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE; uart_tx <= 1'b1; tx_cnt <= '0; tx_bit <= '0; tx_shift <= '0;
    end else begin
      case (tx_state)
        IDLE: if (tx_pop) begin
          tx_state <= START; uart_tx <= 1'b0; tx_cnt <= divisor; tx_shift <= fifo_mem[rd_ptr];
        end
        START: if (tx_cnt == 16'd0) begin
          tx_state <= DATA; uart_tx <= tx_shift[0]; tx_shift <= tx_shift >> 1;
          tx_bit <= '0; tx_cnt <= divisor;
        end else tx_cnt <= tx_cnt - 16'd1;
        DATA: if (tx_cnt == 16'd0) begin
          tx_cnt <= divisor;
          if (tx_bit == 3'd7) begin
            tx_state <= STOP; uart_tx <= 1'b1;
          end else begin
            uart_tx <= tx_shift[0]; tx_shift <= tx_shift >> 1; tx_bit <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt - 16'd1;
        STOP: if (tx_cnt == 16'd0) begin
          if (tx_pop) begin
            tx_state <= START; uart_tx <= 1'b0; tx_cnt <= divisor; tx_shift <= fifo_mem[rd_ptr];
          end else tx_state <= IDLE;
        end else tx_cnt <= tx_cnt - 16'd1;
        default: tx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11; rx_prev <= 1'b1; rx_state <= IDLE;
      rx_cnt <= '0; rx_bit <= '0; rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_s;
      case (rx_state)
        IDLE: if (rx_prev && !rx_s) begin
          rx_state <= START; rx_cnt <= rx_start_load;
        end
        START: if (rx_cnt == 16'd0) begin
          // Line back high at mid-start: treat as a glitch.
          if (rx_s) rx_state <= IDLE;
          else begin rx_state <= DATA; rx_cnt <= divisor; rx_bit <= '0; end
        end else rx_cnt <= rx_cnt - 16'd1;
        DATA: if (rx_cnt == 16'd0) begin
          rx_shift <= {rx_s, rx_shift[7:1]}; rx_cnt <= divisor;
          if (rx_bit == 3'd7) rx_state <= STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt - 16'd1;
        STOP: if (rx_cnt == 16'd0) rx_state <= IDLE;
              else rx_cnt <= rx_cnt - 16'd1;
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Flag sets win over same-cycle clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DefaultDivisor; rx_byte <= '0; rx_valid <= 1'b0;
      rx_overrun <= 1'b0; tx_overflow <= 1'b0; frame_error <= 1'b0;
    end else begin
      if (data_periph_write[3]) divisor <= data_periph_in[15:0];
      if (rx_done_ok) rx_byte <= rx_shift;
      if (rx_done_ok) rx_valid <= 1'b1;
      else if (rx_clr) rx_valid <= 1'b0;
      if (rx_done_ok && rx_valid && !rx_clr) rx_overrun <= 1'b1;
      else if (w1c[0]) rx_overrun <= 1'b0;
      if (tx_ovf_set) tx_overflow <= 1'b1;
      else if (w1c[1]) tx_overflow <= 1'b0;
      if (rx_done_err) frame_error <= 1'b1;
      else if (w1c[2]) frame_error <= 1'b0;
    end
  end
endmodule
